// File: rtl/miniscope_sync_gen.sv
// Miniscope end of the trigger/sync link: turns a held record
// trigger into periodic frame-sync pulses and counts frames.
module miniscope_sync_gen #(
  parameter int unsigned FRAME_PERIOD = 2500000,
  parameter int unsigned SYNC_WIDTH   = 1000,
  parameter int unsigned START_DELAY  = 5000,
  parameter int unsigned FRAME_CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   trig,
  output logic                   sync,
  output logic                   frame_pulse,
  output logic                   recording,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int unsigned PH_W =
    (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam int unsigned DL_W = $clog2(START_DELAY + 1);

  localparam logic [PH_W-1:0] PH_LAST =
    PH_W'(FRAME_PERIOD - 1);
  localparam logic [PH_W-1:0] SW_V =
    PH_W'(SYNC_WIDTH);
  localparam logic [DL_W-1:0] DL_LAST =
    DL_W'(START_DELAY - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic                   trig_m;
  logic                   trig_s;
  logic [1:0]             state;
  logic [1:0]             state_d;
  logic [PH_W-1:0]        phase;
  logic [PH_W-1:0]        phase_d;
  logic [PH_W-1:0]        ph_nxt;
  logic                   ph_wrap;
  logic                   in_win;
  logic [DL_W-1:0]        delay;
  logic [DL_W-1:0]        delay_d;
  logic                   dl_done;
  logic                   sync_d;
  logic                   pulse_d;
  logic [FRAME_CNT_W-1:0] cnt_d;

  // Two-flop synchronizer for the asynchronous trigger
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      trig_m <= 1'b0;
      trig_s <= 1'b0;
    end else begin
      trig_m <= trig;
      trig_s <= trig_m;
    end
  end

  // Next-state logic; a dropped trigger beats a new frame
  always_comb begin
    ph_wrap = (phase == PH_LAST);
    ph_nxt  = ph_wrap ? '0 : phase + 1'b1;
    in_win  = (ph_nxt < SW_V);
    dl_done = (delay == DL_LAST);
    state_d = state;
    phase_d = phase;
    delay_d = delay;
    sync_d  = 1'b0;
    pulse_d = 1'b0;
    cnt_d   = frame_count;
    unique case (state)
      S_IDLE: begin
        if (trig_s) begin
          state_d = S_ARM;
          delay_d = '0;
          cnt_d   = '0;
        end
      end
      S_ARM: begin
        if (!trig_s) begin
          state_d = S_IDLE;
        end else if (dl_done) begin
          state_d = S_RUN;
          phase_d = '0;
          sync_d  = 1'b1;
          pulse_d = 1'b1;
          cnt_d   = frame_count + 1'b1;
        end else begin
          delay_d = delay + 1'b1;
        end
      end
      S_RUN: begin
        phase_d = ph_nxt;
        if (!trig_s) begin
          state_d = S_DRAIN;
          sync_d  = sync && in_win;
        end else begin
          sync_d = in_win;
          if (ph_wrap) begin
            pulse_d = 1'b1;
            cnt_d   = frame_count + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (ph_wrap) begin
          state_d = S_IDLE;
          phase_d = '0;
        end else begin
          phase_d = ph_nxt;
          sync_d  = sync && in_win;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      phase       <= '0;
      delay       <= '0;
      sync        <= 1'b0;
      frame_pulse <= 1'b0;
      recording   <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_d;
      phase       <= phase_d;
      delay       <= delay_d;
      sync        <= sync_d;
      frame_pulse <= pulse_d;
      recording   <= (state_d != S_IDLE);
      frame_count <= cnt_d;
    end
  end

endmodule
